mod461_serial_reducer: RTL
==========================

Name: mod461_serial_reducer

Overview:
- Sequential consumer counterpart to the 6-bit mod-461 residue LUTs.
- Accepts a 400-bit operand as a stream of 6-bit digits, most significant digit first.
- Reduces the operand modulo 461 with Horner accumulation, r <- (r*64 + d) mod 461, at one digit per cycle.
- Returns the 9-bit residue through a valid/ready output handshake. It sits between the operand source and the residue-domain datapath.

Parameters:
- MODULUS, 461: the modulus. Must be odd and less than 2^RES_W.
- DIGIT_W, 6: digit width in bits.
- N_DIGITS, 67: digits per operand (ceil(400/6)). The top digit carries only 4 significant bits, but all 6 of its bits are used as supplied.
- RES_W, 9: residue width.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle request to begin a new operand. Honoured only in IDLE, or in DONE on the cycle the result is accepted.
- in_valid, input, 1: in_digit is valid.
- in_ready, output, 1: block accepts a digit.
- in_digit, input, DIGIT_W: operand digit, MSB-first.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: consumer accepts the result.
- out_residue, output, RES_W: operand mod MODULUS, in the range 0..MODULUS-1.
- busy, output, 1: high in ACCUM or DONE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state goes to IDLE; acc=0; cnt=0.
  - in_ready=0, out_valid=0, out_residue=0, busy=0.
  - Takes effect immediately, including mid-operand or mid-handshake. Any partial operand is discarded and no result is emitted.
- States:
  - IDLE: in_ready=0, out_valid=0. start=1 -> ACCUM, with acc<=0 and cnt<=0.
  - ACCUM: in_ready=1.
    - On in_valid&in_ready: acc <= reduce(acc*2^DIGIT_W + in_digit); cnt <= cnt+1.
    - When the accepted digit is number N_DIGITS (cnt==N_DIGITS-1 at accept) -> DONE on the next edge.
    - start is ignored in ACCUM.
    - in_valid=0 stalls without changing state; there is no timeout.
  - DONE: in_ready=0, out_valid=1, out_residue=acc. Both are held stable until out_ready=1.
    - out_valid&out_ready with start=0 -> IDLE.
    - out_valid&out_ready with start=1 in the same cycle -> ACCUM with acc<=0 and cnt<=0. This gives back-to-back operation with no idle bubble.
    - start without out_ready is ignored.
- Arithmetic:
  - t = acc*64 + d is 15 bits wide; the maximum is 460*64+63 = 29503.
  - reduce(t) is a combinational chain of conditional subtracts of MODULUS<<k for k=6 down to 0, where each stage does "if t >= MODULUS<<k then t -= MODULUS<<k".
  - The final value is always < MODULUS. No multi-cycle reduction is used.
  - acc is registered and is never >= MODULUS.
- Latency:
  - out_valid rises on the edge after the N_DIGITS-th digit is accepted.
  - Minimum start-to-result time is N_DIGITS+1 cycles (68 at the defaults).
- Counter: cnt is wide enough for N_DIGITS (clog2(N_DIGITS+1)). It does not wrap, because the state leaves ACCUM at the terminal count.
- Digits presented while in_ready=0 are not consumed. The source must hold them.
- busy=1 exactly when the state is ACCUM or DONE.

Test Plan:
- Reset and idle:
  - Assert rst_n=0 mid-ACCUM after 30 digits -> all outputs go to 0 immediately and the state is IDLE.
  - Release reset and run a full operand -> the result reflects only the new operand.
- Small parameter override, N_DIGITS=2:
  - Digits 7,13 -> out_residue=0 (461 mod 461).
  - Digits 63,63 -> 407 (4095 mod 461).
  - Digits 0,5 -> 5.
- Default parameters:
  - All digits 0 except the last =5 -> 5.
  - All digits 0 -> 0.
  - Random operands (1000 runs) -> match the bench big-integer model of operand mod 461.
  - Max residue path: operand = 460 (last two digits 7,12) -> 460.
- Backpressure:
  - Toggle in_valid randomly (50%) -> result unchanged versus the unstalled run.
  - Hold out_ready=0 for 10 cycles -> out_valid and out_residue stay stable, and in_ready stays 0.
- Handshake corner cases:
  - start asserted during ACCUM -> ignored, and the current result is correct.
  - start together with out_ready in DONE -> the next operand's first digit can be accepted the following cycle, and both results are correct.
- Throughput: continuous in_valid and out_ready=1 -> exactly N_DIGITS digit accepts per result, and busy is 1 throughout the back-to-back sequence.

Source files
------------

// File: rtl/mod461_serial_reducer_if.sv
// Digit-stream input and residue-result output of the mod-461 serial reducer.
// Both directions are valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface mod461_serial_reducer_if #(
    parameter int DIGIT_W = 6,
    parameter int RES_W   = 9
) ();
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [DIGIT_W-1:0] in_digit;
    logic               out_valid;
    logic               out_ready;
    logic [RES_W-1:0]   out_residue;

    modport master (
        output start, in_valid, in_digit, out_ready,
        input  in_ready, out_valid, out_residue
    );

    modport slave (
        input  start, in_valid, in_digit, out_ready,
        output in_ready, out_valid, out_residue
    );
endinterface

// File: rtl/mod461_serial_reducer.sv
// Horner-style serial reducer: consumes an operand MSB-digit-first and returns operand mod MODULUS.
// One digit per cycle; the residue is held on a valid/ready output until the consumer takes it.
module mod461_serial_reducer #(
    parameter int MODULUS  = 461,
    parameter int DIGIT_W  = 6,
    parameter int N_DIGITS = 67,
    parameter int RES_W    = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mod461_serial_reducer_if.slave  bus,
    output logic                    busy,
    output logic [1:0]              state_dbg
);
    localparam int T_W   = RES_W + DIGIT_W;
    localparam int CNT_W = $clog2(N_DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [RES_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [T_W-1:0]   t;
    logic [RES_W-1:0] acc_nxt;

    assign state_dbg = state;

    // acc < MODULUS, so acc*2^DIGIT_W + d < MODULUS<<DIGIT_W; each conditional
    // subtract of MODULUS<<k leaves t < MODULUS<<k, ending below MODULUS.
    always_comb begin
        t = {acc, bus.in_digit};
        for (int k = DIGIT_W; k >= 0; k--) begin
            if (t >= (T_W'(MODULUS) << k)) begin
                t = t - (T_W'(MODULUS) << k);
            end
        end
        acc_nxt = t[RES_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            acc             <= '0;
            cnt             <= '0;
            bus.in_ready    <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_residue <= '0;
            busy            <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state        <= S_ACCUM;
                        acc          <= '0;
                        cnt          <= '0;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (bus.in_valid && bus.in_ready) begin
                        acc <= acc_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(N_DIGITS - 1)) begin
                            state           <= S_DONE;
                            bus.in_ready    <= 1'b0;
                            bus.out_valid   <= 1'b1;
                            bus.out_residue <= acc_nxt;
                        end
                    end
                end
                S_DONE: begin
                    // A start coinciding with the result handshake restarts immediately.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (bus.start) begin
                            state        <= S_ACCUM;
                            acc          <= '0;
                            cnt          <= '0;
                            bus.in_ready <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    bus.in_ready  <= 1'b0;
                    bus.out_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end
endmodule
